// File: rtl/memory_stage_lsu.sv
// RV32I memory stage: drives a req/ack data bus for lw/sw, stalls upstream while an
// access is outstanding, aborts hung accesses, and holds MEM/WB. Optional: LSU_PERF_CNT_EN.
module memory_stage_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        BusErrM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic is_load, memop, timeout_hit;
  logic req_c, stall_c, bus_err_c, load_w, bubble_w;

  logic        reg_write_w_q, reg_write_w_d;
  logic [1:0]  result_src_w_q, result_src_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] pc_plus4_w_q, pc_plus4_w_d;
  logic [31:0] alu_result_w_q, alu_result_w_d;
  logic [31:0] read_data_w_q, read_data_w_d;

  assign is_load     = (ResultSrcM == 2'b01);
  assign memop       = MemWriteM | is_load;
  assign timeout_hit = (wait_cnt_q == TIMEOUT_LIM);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; an ack in the timeout cycle still completes the access
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (memop && !dmem_ack) begin
          state_d    = WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      WAIT: begin
        if (dmem_ack || timeout_hit) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output logic; everything combinational is forced quiet while rst is high
  always_comb begin
    req_c     = 1'b0;
    stall_c   = 1'b0;
    bus_err_c = 1'b0;
    load_w    = 1'b0;
    bubble_w  = 1'b0;
    case (state_q)
      IDLE: begin
        req_c = memop;
        if (!memop || dmem_ack) begin
          load_w = 1'b1;
        end else begin
          stall_c  = 1'b1;
          bubble_w = 1'b1;
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          load_w = 1'b1;
        end else if (timeout_hit) begin
          bus_err_c = 1'b1;
          bubble_w  = 1'b1;
        end else begin
          stall_c  = 1'b1;
          bubble_w = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      req_c     = 1'b0;
      stall_c   = 1'b0;
      bus_err_c = 1'b0;
      load_w    = 1'b0;
      bubble_w  = 1'b0;
    end
  end

  assign dmem_req   = req_c;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = {ALU_ResultM[31:2], 2'b00};
  assign dmem_wdata = WriteDataM;
  assign StallM     = stall_c;
  assign BusErrM    = bus_err_c;

  // MEM/WB: a bubble only clears the write-back controls, payload fields hold
  always_comb begin
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
    rd_w_d         = rd_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    if (load_w) begin
      reg_write_w_d  = RegWriteM;
      result_src_w_d = ResultSrcM;
      rd_w_d         = RD_M;
      pc_plus4_w_d   = PCPlus4M;
      alu_result_w_d = ALU_ResultM;
      if (is_load) begin
        read_data_w_d = dmem_rdata;
      end
    end
    if (bubble_w) begin
      reg_write_w_d  = 1'b0;
      result_src_w_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
      rd_w_q         <= '0;
      pc_plus4_w_q   <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
    end else begin
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
    end
  end

  assign RegWriteW   = reg_write_w_q;
  assign ResultSrcW  = result_src_w_q;
  assign RD_W        = rd_w_q;
  assign PCPlus4W    = pc_plus4_w_q;
  assign ALU_ResultW = alu_result_w_q;
  assign ReadDataW   = read_data_w_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Bench for memory_stage_lsu: one instruction per issue, a transaction-level model
// predicts the retired MEM/WB contents, stall length and bus error of each instruction.
module tb_memory_stage_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        StallM, BusErrM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, stall_cycles;

  memory_stage_lsu #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .StallM(StallM), .BusErrM(BusErrM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .stall_cycles(stall_cycles)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic        berr;
    logic [31:0] stalls;
    logic [31:0] perf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_w;
  int unsigned m_perf;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_nop();
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; RD_M = '0;
    PCPlus4M = '0; ALU_ResultM = '0; WriteDataM = '0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  // Issues one instruction and plays the memory: ack arrives lat cycles after the
  // request is raised (never, if lat exceeds the timeout). Returns just after the
  // edge on which the instruction leaves MEM.
  task automatic issue(input logic rw, input logic ms, input logic [1:0] rs, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                       input int lat, input logic [31:0] rdata);
    logic memop;
    logic stalled;
    exp_t e;
    int   k;
    memop = ms | (rs == 2'b01);
    if (!memop || lat <= T) begin
      m_w.rw = rw; m_w.rs = rs; m_w.rd = rd; m_w.pc = pc; m_w.alu = alu;
      if (memop && rs == 2'b01) m_w.rdat = rdata;
    end else begin
      m_w.rw = 1'b0; m_w.rs = 2'b00;
    end
    e = m_w;
    e.berr = memop && (lat > T);
    e.stalls = !memop ? 32'd0 : ((lat <= T) ? 32'(lat) : 32'(T));
    m_perf += e.stalls;
`ifdef LSU_PERF_CNT_EN
    e.perf = m_perf;
`else
    e.perf = 32'd0;
`endif
    exp_q.push_back(e);

    RegWriteM = rw; MemWriteM = ms; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
    k = 0;
    forever begin
      dmem_ack   = memop ? (k == lat) : lat[0];
      dmem_rdata = dmem_ack ? rdata : $urandom;
      @(negedge clk);
      check("dmem_req", {31'b0, dmem_req}, {31'b0, memop});
      if (memop) begin
        check("dmem_we", {31'b0, dmem_we}, {31'b0, ms});
        check("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
        check("dmem_wdata", dmem_wdata, wd);
      end
      stalled = StallM;
      @(posedge clk);
      #1;
      if (!stalled) break;
      k++;
      if (k > 4 * T + 8) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_bound: StallM still 1 after %0d cycles, required release", k);
        break;
      end
    end
    dmem_ack = 1'b0;
  endtask

  // Monitor: a retire is any non-reset cycle with StallM low
  exp_t cur;
  logic pend = 1'b0;
  int   scnt = 0;

  always @(negedge clk) begin
    if (pend) begin
      check("RegWriteW", {31'b0, RegWriteW}, {31'b0, cur.rw});
      check("ResultSrcW", {30'b0, ResultSrcW}, {30'b0, cur.rs});
      check("RD_W", {27'b0, RD_W}, {27'b0, cur.rd});
      check("PCPlus4W", PCPlus4W, cur.pc);
      check("ALU_ResultW", ALU_ResultW, cur.alu);
      check("ReadDataW", ReadDataW, cur.rdat);
      check("stall_cycles", stall_cycles, cur.perf);
      pend = 1'b0;
    end
    if (rst) begin
      scnt = 0;
    end else if (StallM) begin
      scnt++;
    end else begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL retire_unexpected: DUT retired with no expected entry at %0t", $time);
      end else begin
        cur = exp_q.pop_front();
        check("BusErrM", {31'b0, BusErrM}, {31'b0, cur.berr});
        check("stall_len", 32'(scnt), cur.stalls);
        pend = 1'b1;
      end
      scnt = 0;
    end
  end

  initial begin
    int          lat, ty, r;
    logic        rw, ms;
    logic [1:0]  rs;

    // Reset with a memop present: combinational outputs must stay quiet
    m_w = '0;
    m_perf = 0;
    set_nop();
    rst = 1'b1;
    MemWriteM = 1'b1;
    dmem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("rst_StallM", {31'b0, StallM}, 32'd0);
      check("rst_BusErrM", {31'b0, BusErrM}, 32'd0);
    end
    check("rst_RegWriteW", {31'b0, RegWriteW}, 32'd0);
    check("rst_ReadDataW", ReadDataW, 32'd0);
    check("rst_ALU_ResultW", ALU_ResultW, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases
    issue(1'b1, 1'b0, 2'b01, 5'd3, 32'h100, 32'h0000_0013, 32'h0, 0, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 2'b00, 5'd5, 32'h104, 32'd7, 32'h0, 0, 32'h0);
    issue(1'b0, 1'b1, 2'b00, 5'd9, 32'h108, 32'h40, 32'hA5A5_0001, 2, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 5'd10, 32'h10C, 32'h44, 32'h0, 99, 32'h5555_AAAA);
    issue(1'b1, 1'b0, 2'b01, 5'd11, 32'h110, 32'h48, 32'h0, T, 32'h1234_5678);
    issue(1'b1, 1'b1, 2'b00, 5'd12, 32'h114, 32'h4C, 32'hCAFE_0000, 1, 32'h0);

    // Reset while waiting: two stall cycles, then rst for one cycle
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RD_M = 5'd20;
    PCPlus4M = 32'h200; ALU_ResultM = 32'h80; dmem_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("wait_StallM", {31'b0, StallM}, 32'd1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rstw_StallM", {31'b0, StallM}, 32'd0);
    check("rstw_dmem_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstw_RegWriteW", {31'b0, RegWriteW}, 32'd0);
    check("rstw_ResultSrcW", {30'b0, ResultSrcW}, 32'd0);
    check("rstw_RD_W", {27'b0, RD_W}, 32'd0);
    check("rstw_PCPlus4W", PCPlus4W, 32'd0);
    check("rstw_ALU_ResultW", ALU_ResultW, 32'd0);
    check("rstw_ReadDataW", ReadDataW, 32'd0);
    check("rstw_stall_cycles", stall_cycles, 32'd0);
    m_w = '0;
    m_perf = 0;
    // Late ack with no memop must be ignored
    issue(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1, 32'hFFFF_FFFF);

    // Random mix of ALU ops, loads and stores with random memory latency
    for (int i = 0; i < 150; i++) begin
      ty  = $urandom_range(0, 2);
      lat = $urandom_range(0, T + 2);
      rw  = 1'($urandom_range(0, 1));
      case (ty)
        0: begin
          ms = 1'b0;
          r  = $urandom_range(0, 2);
          rs = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
        end
        1: begin
          ms = 1'b0;
          rs = 2'b01;
        end
        default: begin
          ms = 1'b1;
          rs = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
        end
      endcase
      issue(rw, ms, rs, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, lat, $urandom);
    end

    // Quiesce and report
    set_nop();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage_lsu.md
# memory_stage_lsu

Memory stage of the RV32I five-stage pipeline: consumes the EX/MEM pipeline outputs, drives a request/acknowledge data-memory bus for `lw`/`sw`, and holds the MEM/WB pipeline register. While a variable-latency memory access is outstanding, it stalls the upstream stages and inserts bubbles into write-back. A timeout aborts hung accesses.

## Interface
Parameters:
- TIMEOUT_CYC, 255: maximum number of WAIT cycles before an access is aborted (range 1..65535).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; rising edge.
- rst  in  1  synchronous active-high reset.
- RegWriteM  in  1  register write enable from EX/MEM.
- MemWriteM  in  1  store request from EX/MEM.
- ResultSrcM  in  2  result select; 2'b01 = load.
- RD_M  in  5  destination register.
- PCPlus4M  in  32  PC+4 of the instruction in MEM.
- ALU_ResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  word address, {ALU_ResultM[31:2],2'b00}.
- dmem_wdata  out  32  equals WriteDataM.
- dmem_rdata  in  32  read data; valid only while dmem_ack=1.
- dmem_ack  in  1  single-cycle completion pulse.
- StallM  out  1  to hazard unit; freezes F/D/E and EX/MEM while 1.
- BusErrM  out  1  one-cycle pulse on timeout abort.
- RegWriteW, ResultSrcW[1:0], RD_W[4:0], PCPlus4W[31:0], ALU_ResultW[31:0], ReadDataW[31:0]  out  MEM/WB register contents.
- stall_cycles  out  32  performance counter (see Configuration).

## Operation
- memop = MemWriteM | (ResultSrcM == 2'b01). Address bits [1:0] are dropped; the block performs word accesses only.
- The FSM has two states, IDLE and WAIT.
- In IDLE:
  - dmem_req = memop (combinational); dmem_we = MemWriteM.
  - memop & dmem_ack: the access completes with no stall, and MEM/WB loads.
  - memop & !dmem_ack: StallM = 1, the MEM/WB register loads a bubble, and the FSM moves to WAIT with wait_cnt = 1.
  - !memop: MEM/WB loads the inputs directly. dmem_ack is ignored.
- In WAIT:
  - dmem_req = 1, and the bus outputs stay stable because the upstream stages are frozen.
  - dmem_ack: StallM = 0, MEM/WB loads (ReadDataW = dmem_rdata), and the FSM returns to IDLE.
  - !dmem_ack & wait_cnt == TIMEOUT_CYC: abort. BusErrM = 1 and StallM = 0. MEM/WB loads a bubble (the load is not written back). The FSM returns to IDLE.
  - Otherwise: StallM = 1, wait_cnt increments, and MEM/WB loads a bubble.
- Bubble means RegWriteW = 0 and ResultSrcW = 0. All other W fields hold their previous values.
- ReadDataW updates only on a load completion. Stores and non-memory instructions leave it unchanged.
- If dmem_ack and the timeout occur in the same cycle, the ack wins.

## Timing
- Reset: state = IDLE, wait_cnt = 0, every W output = 0, BusErrM = 0, stall_cycles = 0.
- While rst = 1, StallM = 0 and dmem_req = 0 (the combinational outputs are gated by rst).
- MEM to W latency is 1 cycle with a zero-wait memory. An access acknowledged N cycles after the request was raised takes N+1 cycles.
- Stall length is N cycles for ack on cycle N, and at most TIMEOUT_CYC cycles.
- Reset asserted in WAIT: the outstanding access is abandoned. A late dmem_ack that arrives after reset is ignored if no memop is present.
- Back-to-back memory ops: a new request may be raised in the cycle immediately after a completion.

## Configuration
- LSU_PERF_CNT_EN defined: stall_cycles increments on every clk edge where StallM = 1, saturates at 32'hFFFFFFFF, and is cleared only by rst.
- LSU_PERF_CNT_EN undefined: the counter logic is absent and stall_cycles is tied to 32'h0. The port is kept for bench compatibility.

## Test plan
- Zero-wait load: ResultSrcM = 01, ALU_ResultM = 32'h0000_0013, dmem_ack = 1 in the same cycle, dmem_rdata = 32'hDEAD_BEEF -> dmem_addr = 32'h10, StallM never 1, next cycle ReadDataW = 32'hDEADBEEF and RegWriteW = 1.
- 3-cycle store: MemWriteM = 1, WriteDataM = 32'hA5A5_0001, ack on the 3rd request cycle -> StallM = 1 for 2 cycles, dmem_we = 1 throughout, RegWriteW = 0, stall_cycles = 2 (with the macro defined).
- Timeout with TIMEOUT_CYC = 4: load, ack never arrives -> StallM high for 4 cycles, one BusErrM pulse, RegWriteW stays 0, FSM returns to IDLE.
- ALU instruction (RegWriteM = 1, RD_M = 5, ALU_ResultM = 7, no memop) -> dmem_req = 0, next cycle RD_W = 5, ALU_ResultW = 7, RegWriteW = 1.
- Reset during WAIT after 2 stall cycles -> next cycle StallM = 0, dmem_req = 0, all W outputs = 0, stall_cycles = 0.
- Ack and timeout coincide (TIMEOUT_CYC = 2, ack on WAIT cycle 2) -> load completes, BusErrM stays 0.
